// File: rtl/duty_cycle_meter.sv
// Multi-channel duty-cycle meter: counts high cycles per channel over WIN_LEN enabled cycles.
// Optional macro DUTY_SYNC_EN adds a 2-flop synchronizer on every ring_in bit.
module duty_cycle_meter #(
  parameter int CHANNELS = 4,
  parameter int WIN_LEN  = 255,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       ring_in,
  input  logic                      enable,
  input  logic                      cont,
  input  logic                      start,
  output logic [CHANNELS*CNT_W-1:0] value,
  output logic                      valid,
  output logic                      busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    wcnt_reg;
  logic                valid_reg;
  logic [CHANNELS-1:0] sample;
  logic                win_end;
  logic                clear;

`ifdef DUTY_SYNC_EN
  logic [CHANNELS-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= ring_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample = sync2_reg;
`else
  assign sample = ring_in;
`endif

  assign win_end = (state_reg == RUN) && enable && (wcnt_reg == CNT_W'(WIN_LEN - 1));
  // Counters clear while idle, at window end, and on a restart (which discards this edge's sample).
  assign clear   = (state_reg != RUN) || win_end || start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start || cont) state_next = RUN;
      RUN:  if (win_end && !cont && !start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= win_end;
      if (clear) begin
        wcnt_reg <= '0;
      end else if (enable) begin
        wcnt_reg <= wcnt_reg + CNT_W'(1);
      end
    end
  end

  assign valid = valid_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CNT_W-1:0] hcnt_reg;
      logic [CNT_W-1:0] value_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hcnt_reg  <= '0;
          value_reg <= '0;
        end else begin
          if (clear) begin
            hcnt_reg <= '0;
          end else if (enable && sample[gi]) begin
            hcnt_reg <= hcnt_reg + CNT_W'(1);
          end
          // The final sample is folded in here so the result covers all WIN_LEN samples.
          if (win_end) begin
            value_reg <= hcnt_reg + CNT_W'(sample[gi]);
          end
        end
      end

      assign value[gi*CNT_W +: CNT_W] = value_reg;
    end
  endgenerate

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Scoreboard bench for duty_cycle_meter: a window-level reference model predicts results,
// a negedge monitor compares busy/valid/value every cycle.
module tb_duty_cycle_meter;
  localparam int CH = 4;
  localparam int WL = 255;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    ring_in;
  logic             enable;
  logic             cont;
  logic             start;
  logic [CH*CW-1:0] value;
  logic             valid;
  logic             busy;

  int tests = 0;
  int fails = 0;

  logic [CH-1:0]    win_q[$];
  logic [CH*CW-1:0] exp_q[$];
  bit               m_run;
  logic [CH*CW-1:0] m_value;
  logic [CH-1:0]    pin_d1, pin_d2;

  duty_cycle_meter #(.CHANNELS(CH), .WIN_LEN(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .enable(enable),
    .cont(cont), .start(start), .value(value), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Duty count per channel = number of high samples in the completed window.
  function automatic logic [CH*CW-1:0] tally();
    logic [CH*CW-1:0] r;
    int n;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      n = 0;
      foreach (win_q[k]) n += int'(win_q[k][c]);
      r[c*CW +: CW] = CW'(n);
    end
    return r;
  endfunction

  // Reference model: collects enabled samples of the running window into a queue.
  initial begin
    logic [CH-1:0] s;
    m_run = 0; m_value = '0; pin_d1 = '0; pin_d2 = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_value = '0; pin_d1 = '0; pin_d2 = '0;
        win_q.delete(); exp_q.delete();
      end else begin
`ifdef DUTY_SYNC_EN
        s = pin_d2; pin_d2 = pin_d1; pin_d1 = ring_in;
`else
        s = ring_in;
`endif
        if (!m_run) begin
          m_run = start || cont;
        end else begin
          if (enable) win_q.push_back(s);
          if (win_q.size() == WL) begin
            m_value = tally();
            exp_q.push_back(m_value);
            win_q.delete();
            m_run = cont || start;
          end else if (start) begin
            win_q.delete();
          end
        end
      end
    end
  end

  // Monitor: valid must appear exactly when the model has a pending result.
  initial begin
    logic [CH*CW-1:0] e;
    forever begin
      @(negedge clk);
      chk("busy", 64'(busy), 64'(m_run));
      chk("valid", 64'(valid), 64'(exp_q.size() != 0));
      if (valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", 64'(value), 64'(e));
      end
      chk("value_hold", 64'(value), 64'(m_value));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain();
    cont = 1'b0; start = 1'b0; enable = 1'b1;
    tick(2 * WL + 10);
  endtask

  initial begin
    rst_n = 1'b0; ring_in = '0; enable = 1'b0; cont = 1'b0; start = 1'b0;
    tick(3);
    chk("rst_value", 64'(value), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #1 rst_n = 1'b1;

    // Continuous, all high: every channel reports WL.
    $display("[TB] phase: continuous all-high");
    ring_in = '1; enable = 1'b1; cont = 1'b1;
    tick(2 * WL + 5);

    // ch0 toggling, ch1 low.
    $display("[TB] phase: ch0 toggling");
    drain();
    ring_in = 4'b0001; cont = 1'b1;
    repeat (2 * WL + 5) begin
      tick(1);
      ring_in[0] = ~ring_in[0];
    end

    // Enable alternating halves the window rate.
    $display("[TB] phase: enable alternating");
    drain();
    ring_in = '1; cont = 1'b1;
    repeat (2 * 2 * WL + 5) begin
      tick(1);
      enable = ~enable;
    end

    // One-shot on ch2, then a long quiet period.
    $display("[TB] phase: one-shot");
    drain();
    ring_in = 4'b0100; enable = 1'b1;
    pulse_start();
    tick(WL + 1000);
    chk("oneshot_busy", 64'(busy), 64'd0);

    // Restart mid-window, then reset mid-window: no result from either.
    $display("[TB] phase: restart and reset");
    ring_in = 4'b1011;
    pulse_start();
    tick(100);
    pulse_start();
    tick(50);
    #1 rst_n = 1'b0;
    tick(2);
    chk("midrst_value", 64'(value), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    #1 rst_n = 1'b1;
    tick(2);

    // Randomized traffic: random pins, sparse enable gaps, rare restarts and mode flips.
    $display("[TB] phase: random");
    cont = 1'b1;
    repeat (4000) begin
      ring_in = CH'($urandom);
      enable  = ($urandom_range(0, 3) != 0);
      start   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 999) == 0) cont = ~cont;
      tick(1);
    end
    start = 1'b0;
    drain();
    tick(5);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
